inst_cache_sa: RTL and testbench

- Parametrised set-associative instruction cache between the fetch stage and a word-wide instruction memory.
- Fetch issues a word address on `ptr` with an `inst_get` pulse.
  - Hit: the instruction is returned one cycle later.
  - Miss: the whole block is refilled from memory over a valid-handshake bus, then the instruction is returned.
- Adds what the previous single-configuration cache lacked: valid bits, tag compare, victim selection, refill FSM and a real `ready` protocol.

---
 rtl/inst_cache_sa_if.sv | 25 ++
 rtl/inst_cache_sa.sv | 162 ++++++++++++++++
 tb/tb_inst_cache_sa.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_cache_sa_if.sv
// Fetch-side and refill-side signals of the set-associative instruction cache.
// The cache uses the slave modport; the fetch stage and memory use master.
interface inst_cache_sa_if #(
  parameter int WORD_SIZE = 32
);
  logic                 inst_get;
  logic [WORD_SIZE-1:0] ptr;
  logic [WORD_SIZE-1:0] out;
  logic                 ready;
  logic                 busy;
  logic                 mem_req;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_data;
  logic                 mem_valid;

  modport slave (
    input  inst_get, ptr, mem_data, mem_valid,
    output out, ready, busy, mem_req, mem_addr
  );

  modport master (
    output inst_get, ptr, mem_data, mem_valid,
    input  out, ready, busy, mem_req, mem_addr
  );
endinterface

// File: rtl/inst_cache_sa.sv
// Set-associative instruction cache with block refill over a valid-handshake bus.
// Optional macro ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module inst_cache_sa #(
  parameter int WORD_SIZE    = 32,
  parameter int SET_SIZE     = 64,
  parameter int CHANNEL_SIZE = 2,
  parameter int BLOCK_SIZE   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inst_cache_sa_if.slave       bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);
  localparam int OFF_W    = $clog2(BLOCK_SIZE);
  localparam int IDX_W    = $clog2(SET_SIZE);
  localparam int TAG_SIZE = WORD_SIZE - IDX_W - OFF_W;
  localparam int WAY_W    = (CHANNEL_SIZE > 1) ? $clog2(CHANNEL_SIZE) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_t;
  state_t state_q, state_d;

  logic [WORD_SIZE-1:0]    p_q;
  logic [OFF_W-1:0]        p_off;
  logic [IDX_W-1:0]        p_idx;
  logic [TAG_SIZE-1:0]     p_tag;
  logic [OFF_W-1:0]        beat_q, beat_nx;
  logic [WAY_W-1:0]        vic_q, vic_nx, victim, hit_way, inv_way;
  logic                    vic_adv_q, hit, has_inv;

  logic [WORD_SIZE-1:0]    data_q  [SET_SIZE][CHANNEL_SIZE][BLOCK_SIZE];
  logic [TAG_SIZE-1:0]     tag_q   [SET_SIZE][CHANNEL_SIZE];
  logic [CHANNEL_SIZE-1:0] vld_q   [SET_SIZE];
  logic [WAY_W-1:0]        vptr_q  [SET_SIZE];

  logic                    ready_q, busy_q, mem_req_q;
  logic [WORD_SIZE-1:0]    mem_addr_q, out_q;
  logic                    accept, hit_go, miss_go, beat_go, last_go, resp_go;

  assign p_off   = p_q[OFF_W-1:0];
  assign p_idx   = p_q[OFF_W+IDX_W-1:OFF_W];
  assign p_tag   = p_q[WORD_SIZE-1:OFF_W+IDX_W];
  assign beat_nx = beat_q + OFF_W'(1);
  assign vic_nx  = (vic_q == WAY_W'(CHANNEL_SIZE-1)) ? '0 : vic_q + WAY_W'(1);
  assign victim  = has_inv ? inv_way : vptr_q[p_idx];

  assign bus.out      = out_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;

  // Tag compare and victim choice for the latched request
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = 0; w < CHANNEL_SIZE; w++) begin
      if (vld_q[p_idx][w] && (tag_q[p_idx][w] == p_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = CHANNEL_SIZE - 1; w >= 0; w--) begin
      if (!vld_q[p_idx][w]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    hit_go  = 1'b0;
    miss_go = 1'b0;
    beat_go = 1'b0;
    last_go = 1'b0;
    resp_go = 1'b0;
    case (state_q)
      IDLE:    if (bus.inst_get) begin accept = 1'b1; state_d = LOOKUP; end
      LOOKUP:  if (hit) begin hit_go = 1'b1; state_d = IDLE; end
               else begin miss_go = 1'b1; state_d = REFILL; end
      REFILL:  if (bus.mem_valid) begin
                 beat_go = 1'b1;
                 if (beat_q == OFF_W'(BLOCK_SIZE-1)) begin last_go = 1'b1; state_d = RESPOND; end
               end
      RESPOND: begin resp_go = 1'b1; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
  end

  // Control state: handshake outputs, valid bits, victim pointers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      out_q      <= '0;
      for (int s = 0; s < SET_SIZE; s++) begin
        vld_q[s]  <= '0;
        vptr_q[s] <= '0;
      end
    end else begin
      ready_q <= hit_go || resp_go;
      if (accept)                 busy_q <= 1'b1;
      else if (hit_go || resp_go) busy_q <= 1'b0;
      if (hit_go) out_q <= data_q[p_idx][hit_way][p_off];
      if (miss_go) begin
        vld_q[p_idx][victim] <= 1'b0;
        mem_req_q            <= 1'b1;
        mem_addr_q           <= {p_tag, p_idx, {OFF_W{1'b0}}};
      end
      if (beat_go) begin
        if (beat_q == p_off) out_q <= bus.mem_data;
        mem_addr_q <= {mem_addr_q[WORD_SIZE-1:OFF_W], beat_nx};
      end
      if (last_go) begin
        mem_req_q           <= 1'b0;
        vld_q[p_idx][vic_q] <= 1'b1;
        if (vic_adv_q) vptr_q[p_idx] <= vic_nx;
      end
    end
  end

  // Storage and request datapath; never reset
  always_ff @(posedge clk) begin
    if (accept) p_q <= bus.ptr;
    if (miss_go) begin
      tag_q[p_idx][victim] <= p_tag;
      vic_q                <= victim;
      vic_adv_q            <= !has_inv;
      beat_q               <= '0;
    end
    if (beat_go) begin
      data_q[p_idx][vic_q][beat_q] <= bus.mem_data;
      beat_q                       <= beat_nx;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_go && (hit_count != '1))   hit_count  <= hit_count + 32'd1;
      if (miss_go && (miss_count != '1)) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_inst_cache_sa.sv
// Randomized self-checking bench for inst_cache_sa against a per-set LRU-free
// replacement model and an address-derived memory image.
module tb_inst_cache_sa;
  localparam int WS   = 32;
  localparam int SETS = 64;
  localparam int CH   = 2;
  localparam int BLK  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  inst_cache_sa_if #(.WORD_SIZE(WS)) bus();
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  inst_cache_sa #(.WORD_SIZE(WS), .SET_SIZE(SETS), .CHANNEL_SIZE(CH), .BLOCK_SIZE(BLK)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stall_n = 1;
  bit noise = 1'b0;
  logic [31:0] addr_q[$];

  // Reference model: per-set valid/tag per way plus a round-robin pointer
  bit          mv [SETS][CH];
  logic [31:0] mt [SETS][CH];
  int          vp [SETS];
  int          m_hits, m_miss;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return ((a >> 4) << 12) | (a & 32'hF);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      vp[s] = 0;
      for (int w = 0; w < CH; w++) mv[s][w] = 1'b0;
    end
    m_hits = 0;
    m_miss = 0;
  endfunction

  function automatic bit model_access(input logic [31:0] a);
    int s, v;
    logic [31:0] t;
    s = int'((a / BLK) % SETS);
    t = a / (BLK * SETS);
    for (int w = 0; w < CH; w++)
      if (mv[s][w] && mt[s][w] == t) begin m_hits++; return 1'b0; end
    v = -1;
    for (int w = 0; w < CH; w++) if (!mv[s][w] && v < 0) v = w;
    if (v < 0) begin v = vp[s]; vp[s] = (vp[s] + 1) % CH; end
    mv[s][v] = 1'b1;
    mt[s][v] = t;
    m_miss++;
    return 1'b1;
  endfunction

  // Memory responder: one beat every stall_n cycles of mem_req
  initial begin
    int rcnt;
    rcnt = 0;
    bus.mem_valid = 1'b0;
    bus.mem_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_req) begin
        if (rcnt % stall_n == stall_n - 1) begin
          bus.mem_valid = 1'b1;
          bus.mem_data  = mdata(bus.mem_addr);
          addr_q.push_back(bus.mem_addr);
        end else bus.mem_valid = 1'b0;
        rcnt++;
      end else begin
        rcnt = 0;
        if (noise && $urandom_range(0, 2) == 0) begin
          bus.mem_valid = 1'b1;
          bus.mem_data  = $urandom;
        end else bus.mem_valid = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic do_fetch(input logic [31:0] a, input bit spam, output logic [31:0] o,
                          output int lat, output int reqc, output int extra,
                          output bit busy_acc, output bit busy_rdy, output bit tmo);
    addr_q.delete();
    @(negedge clk); bus.ptr = a; bus.inst_get = 1'b1;
    @(posedge clk); #1; bus.inst_get = 1'b0;
    lat = 1; reqc = 0; extra = 0; tmo = 1'b0; busy_acc = bus.busy;
    while (!bus.ready && !tmo) begin
      if (bus.mem_req) reqc++;
      if (spam) begin bus.inst_get = 1'($urandom_range(0, 1)); bus.ptr = $urandom; end
      @(posedge clk); #1; bus.inst_get = 1'b0; lat++;
      if (lat > 1000) tmo = 1'b1;
    end
    o = bus.out;
    busy_rdy = bus.busy;
    repeat (4) begin @(posedge clk); #1; if (bus.ready) extra++; end
  endtask

  task automatic test_reset();
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    checks++; if (bus.out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h want 0", bus.out); end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_cold_miss();
    logic [31:0] o; int lat, reqc, extra; bit ba, br, tmo, ms;
    stall_n = 1;
    ms = model_access(32'h13);
    do_fetch(32'h13, 1'b0, o, lat, reqc, extra, ba, br, tmo);
    checks++; if (tmo || !ms) begin errors++; $display("FAIL cold_tmo: timeout %b model_miss %b want 0/1", tmo, ms); end
    checks++; if (ba !== 1'b1) begin errors++; $display("FAIL cold_busy_acc: got %b want 1", ba); end
    checks++; if (reqc != 16) begin errors++; $display("FAIL cold_req_cycles: got %0d want 16", reqc); end
    checks++; if (addr_q.size() != 16) begin errors++; $display("FAIL cold_beats: got %0d want 16", addr_q.size()); end
    for (int i = 0; i < addr_q.size() && i < 16; i++) begin
      checks++;
      if (addr_q[i] !== 32'h10 + 32'(i)) begin errors++; $display("FAIL cold_addr[%0d]: got %h want %h", i, addr_q[i], 32'h10 + 32'(i)); end
    end
    checks++; if (o !== 32'h1003) begin errors++; $display("FAIL cold_out: got %h want 00001003", o); end
    checks++; if (br !== 1'b0) begin errors++; $display("FAIL cold_busy_rdy: got %b want 0", br); end
    checks++; if (extra != 0) begin errors++; $display("FAIL cold_extra_ready: got %0d want 0", extra); end
  endtask

  task automatic test_hit_after_fill();
    logic [31:0] o; int lat, reqc, extra; bit ba, br, tmo, ms;
    ms = model_access(32'h1A);
    do_fetch(32'h1A, 1'b0, o, lat, reqc, extra, ba, br, tmo);
    checks++; if (ms || lat != 2) begin errors++; $display("FAIL hit_latency: got %0d want 2 (model_miss %b)", lat, ms); end
    checks++; if (reqc != 0) begin errors++; $display("FAIL hit_mem_req: got %0d cycles want 0", reqc); end
    checks++; if (o !== 32'h100A) begin errors++; $display("FAIL hit_out: got %h want 0000100a", o); end
`ifdef ICACHE_STATS_EN
    checks++; if (hit_count !== 32'(m_hits) || miss_count !== 32'(m_miss)) begin
      errors++; $display("FAIL hit_stats: got %0d/%0d want %0d/%0d", hit_count, miss_count, m_hits, m_miss); end
`endif
  endtask

  task automatic test_replacement();
    logic [31:0] seq [5] = '{32'h000, 32'h400, 32'h800, 32'h405, 32'h005};
    bit exp_m [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] o; int lat, reqc, extra; bit ba, br, tmo, ms;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ms = model_access(seq[i]);
      do_fetch(seq[i], 1'b0, o, lat, reqc, extra, ba, br, tmo);
      checks++; if ((reqc > 0) !== exp_m[i] || ms !== exp_m[i]) begin
        errors++; $display("FAIL repl_miss[%h]: got %b want %b (model %b)", seq[i], reqc > 0, exp_m[i], ms); end
      checks++; if (o !== mdata(seq[i])) begin errors++; $display("FAIL repl_out[%h]: got %h want %h", seq[i], o, mdata(seq[i])); end
    end
  endtask

  task automatic test_stalled();
    logic [31:0] o; int lat, reqc, extra; bit ba, br, tmo, ms;
    stall_n = 3;
    ms = model_access(32'h2345);
    do_fetch(32'h2345, 1'b1, o, lat, reqc, extra, ba, br, tmo);
    stall_n = 1;
    checks++; if (!ms || reqc != 48) begin errors++; $display("FAIL stall_req_cycles: got %0d want 48", reqc); end
    checks++; if (o !== mdata(32'h2345)) begin errors++; $display("FAIL stall_out: got %h want %h", o, mdata(32'h2345)); end
    checks++; if (extra != 0) begin errors++; $display("FAIL stall_extra_ready: got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] a = 32'h3450;
    logic [31:0] o; int lat, reqc, extra, n; bit ba, br, tmo, ms;
    stall_n = 1;
    addr_q.delete();
    @(negedge clk); bus.ptr = a; bus.inst_get = 1'b1;
    @(posedge clk); #1; bus.inst_get = 1'b0;
    n = 0;
    while (addr_q.size() < 8 && n < 200) begin @(negedge clk); n++; end
    checks++; if (n >= 200) begin errors++; $display("FAIL midrst_wait: got %0d beats want 8", addr_q.size()); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.ready !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl: got req/rdy/busy %b%b%b want 000", bus.mem_req, bus.ready, bus.busy); end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    ms = model_access(a);
    do_fetch(a, 1'b0, o, lat, reqc, extra, ba, br, tmo);
    checks++; if (!ms || reqc != 16 || addr_q.size() != 16) begin
      errors++; $display("FAIL midrst_refill: got %0d cycles %0d beats want 16/16", reqc, addr_q.size()); end
    checks++; if (o !== mdata(a)) begin errors++; $display("FAIL midrst_out: got %h want %h", o, mdata(a)); end
  endtask

  task automatic test_boundary();
    logic [31:0] o; int lat, reqc, extra; bit ba, br, tmo, ms;
    ms = model_access(32'hFFFF_FFFF);
    do_fetch(32'hFFFF_FFFF, 1'b0, o, lat, reqc, extra, ba, br, tmo);
    checks++; if (!ms || addr_q.size() != 16) begin errors++; $display("FAIL bound_beats: got %0d want 16", addr_q.size()); end
    for (int i = 0; i < addr_q.size() && i < 16; i++) begin
      checks++;
      if (addr_q[i] !== 32'hFFFF_FFF0 + 32'(i)) begin errors++; $display("FAIL bound_addr[%0d]: got %h want %h", i, addr_q[i], 32'hFFFF_FFF0 + 32'(i)); end
    end
    checks++; if (o !== mdata(32'hFFFF_FFFF)) begin errors++; $display("FAIL bound_out: got %h want %h", o, mdata(32'hFFFF_FFFF)); end
    ms = model_access(32'hFFFF_FFF8);
    do_fetch(32'hFFFF_FFF8, 1'b0, o, lat, reqc, extra, ba, br, tmo);
    checks++; if (ms || reqc != 0 || lat != 2) begin errors++; $display("FAIL bound_rehit: got lat %0d req %0d want 2/0", lat, reqc); end
    checks++; if (o !== mdata(32'hFFFF_FFF8)) begin errors++; $display("FAIL bound_rehit_out: got %h want %h", o, mdata(32'hFFFF_FFF8)); end
  endtask

  task automatic test_random();
    logic [31:0] a, o; int lat, reqc, extra; bit ba, br, tmo, ms, spam;
    noise = 1'b1;
    for (int k = 0; k < 150; k++) begin
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
      stall_n = $urandom_range(1, 2);
      spam = 1'($urandom_range(0, 1));
      ms = model_access(a);
      do_fetch(a, spam, o, lat, reqc, extra, ba, br, tmo);
      checks++; if (tmo || o !== mdata(a)) begin errors++; $display("FAIL rand_out[%h]: got %h want %h", a, o, mdata(a)); end
      checks++; if (reqc != (ms ? 16 * stall_n : 0)) begin
        errors++; $display("FAIL rand_req[%h]: got %0d cycles want %0d", a, reqc, ms ? 16 * stall_n : 0); end
      checks++; if (!ms && lat != 2) begin errors++; $display("FAIL rand_hit_lat[%h]: got %0d want 2", a, lat); end
      checks++; if (extra != 0) begin errors++; $display("FAIL rand_extra_ready[%h]: got %0d want 0", a, extra); end
    end
    noise = 1'b0;
    stall_n = 1;
`ifdef ICACHE_STATS_EN
    checks++; if (hit_count !== 32'(m_hits) || miss_count !== 32'(m_miss)) begin
      errors++; $display("FAIL rand_stats: got %0d/%0d want %0d/%0d", hit_count, miss_count, m_hits, m_miss); end
`endif
  endtask

  initial begin
    bus.inst_get = 1'b0;
    bus.ptr      = '0;
    model_reset();
    test_reset();
    test_cold_miss();
    test_hit_after_fill();
    test_replacement();
    test_stalled();
    test_reset_mid_refill();
    test_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
